adxl345_seq: RTL and testbench

//   Transaction sequencer for the on-board ADXL345 accelerometer on HPS I2C1.

---
 rtl/adxl345_seq.sv | 204 ++++++++++++++++++++
 tb/tb_adxl345_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adxl345_seq.sv
// ADXL345 transaction sequencer: runs the register init table, then issues periodic
// 6-byte burst reads through a byte-level I2C master over a cmd/rsp handshake.
module adxl345_seq #(
  parameter logic [6:0]  DEV_ADDR   = 7'h53,
  parameter int unsigned SAMPLE_DIV = 500000,
  parameter int unsigned RETRY_WAIT = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic [7:0]  cmd_data,
  output logic        cmd_nack,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_nack,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        busy,
  output logic        error
);

  localparam int unsigned TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned WW = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(SAMPLE_DIV - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(RETRY_WAIT - 1);

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;

  typedef enum logic [4:0] {
    StIdle, StInitStart, StInitAddr, StInitReg, StInitData, StInitStop, StWaitTick,
    StRdStart, StRdAddrW, StRdReg, StRdRestart, StRdAddrR, StRdByte, StRdStop,
    StPublish, StErrStop, StErrWait
  } state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [2:0]    bcnt;
  logic          pend;
  logic          tick_pend;
  logic [TW-1:0] tick_cnt;
  logic [WW-1:0] wait_cnt;
  logic [47:0]   shadow;

  logic          is_cmd;
  logic [1:0]    op;
  logic [7:0]    data;
  logic          nack;
  logic          tick;
  logic          nacked;
  logic [15:0]   entry;

  function automatic logic [15:0] init_entry(input logic [2:0] i);
    case (i)
      3'd0:    init_entry = 16'h310B;
      3'd1:    init_entry = 16'h2C0B;
      3'd2:    init_entry = 16'h2404;
      3'd3:    init_entry = 16'h2502;
      3'd4:    init_entry = 16'h2602;
      3'd5:    init_entry = 16'h27FF;
      3'd6:    init_entry = 16'h2D00;
      default: init_entry = 16'h2D08;
    endcase
  endfunction

  assign entry  = init_entry(idx);
  assign tick   = init_done && (tick_cnt == TICK_MAX);
  assign nacked = is_cmd && (op == OP_WRITE) && rsp_nack;
  assign busy   = (state != StIdle);

  // Command implied by the current state; latched into cmd_* when issued.
  always_comb begin
    is_cmd = 1'b1;
    op     = OP_START;
    data   = 8'h00;
    nack   = 1'b0;
    unique case (state)
      StInitStart, StRdStart, StRdRestart: op = OP_START;
      StInitStop, StRdStop, StErrStop:     op = OP_STOP;
      StInitAddr, StRdAddrW: begin op = OP_WRITE; data = {DEV_ADDR, 1'b0}; end
      StInitReg:             begin op = OP_WRITE; data = entry[15:8]; end
      StInitData:            begin op = OP_WRITE; data = entry[7:0]; end
      StRdReg:               begin op = OP_WRITE; data = 8'h32; end
      StRdAddrR:             begin op = OP_WRITE; data = {DEV_ADDR, 1'b1}; end
      StRdByte:              begin op = OP_READ; nack = (bcnt == 3'd5); end
      default:               is_cmd = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= StIdle;
      idx          <= '0;
      bcnt         <= '0;
      pend         <= 1'b0;
      tick_pend    <= 1'b0;
      tick_cnt     <= '0;
      wait_cnt     <= '0;
      shadow       <= '0;
      cmd_valid    <= 1'b0;
      cmd_op       <= '0;
      cmd_data     <= '0;
      cmd_nack     <= 1'b0;
      accel_x      <= '0;
      accel_y      <= '0;
      accel_z      <= '0;
      sample_valid <= 1'b0;
      init_done    <= 1'b0;
      error        <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!init_done || tick) tick_cnt <= '0;
      else                    tick_cnt <= tick_cnt + 1'b1;
      // A tick arriving mid-burst is held (1-deep) until WAIT_TICK is reached again.
      if (tick && state != StWaitTick) tick_pend <= 1'b1;

      if (is_cmd && !cmd_valid && !pend) begin
        cmd_valid <= 1'b1;
        cmd_op    <= op;
        cmd_data  <= data;
        cmd_nack  <= nack;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
        pend      <= 1'b1;
      end

      unique case (state)
        StIdle: if (enable) begin state <= StInitStart; idx <= '0; end
        StWaitTick: begin
          if (!enable) state <= StIdle;
          else if (tick || tick_pend) begin
            tick_pend <= 1'b0;
            state     <= StRdStart;
          end
        end
        StPublish: state <= enable ? StWaitTick : StIdle;
        StErrWait: begin
          if (!enable) state <= StIdle;
          else if (wait_cnt == WAIT_MAX) begin state <= StInitStart; idx <= '0; end
          else wait_cnt <= wait_cnt + 1'b1;
        end
        default: begin
          if (pend && rsp_valid) begin
            pend <= 1'b0;
            if (nacked) begin
              error     <= 1'b1;
              init_done <= 1'b0;
              tick_pend <= 1'b0;
              state     <= StErrStop;
            end else begin
              case (state)
                StInitStart: state <= StInitAddr;
                StInitAddr:  state <= StInitReg;
                StInitReg:   state <= StInitData;
                StInitData:  state <= StInitStop;
                StInitStop: begin
                  if (idx == 3'd7) begin
                    init_done <= 1'b1;
                    state     <= enable ? StWaitTick : StIdle;
                  end else begin
                    idx   <= idx + 1'b1;
                    state <= enable ? StInitStart : StIdle;
                  end
                end
                StRdStart:   state <= StRdAddrW;
                StRdAddrW:   state <= StRdReg;
                StRdReg:     state <= StRdRestart;
                StRdRestart: state <= StRdAddrR;
                StRdAddrR:   begin state <= StRdByte; bcnt <= '0; end
                StRdByte: begin
                  // Shift in from the top so byte 0 ends up in shadow[7:0].
                  shadow <= {rsp_data, shadow[47:8]};
                  if (bcnt == 3'd5) state <= StRdStop;
                  else              bcnt  <= bcnt + 1'b1;
                end
                StRdStop: begin
                  accel_x      <= shadow[15:0];
                  accel_y      <= shadow[31:16];
                  accel_z      <= shadow[47:32];
                  sample_valid <= 1'b1;
                  state        <= StPublish;
                end
                StErrStop: begin
                  wait_cnt <= '0;
                  state    <= enable ? StErrWait : StIdle;
                end
                default: state <= StIdle;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adxl345_seq.sv
// Self-checking bench for adxl345_seq: a randomized I2C-master BFM plus a
// command-list / byte-queue reference model built from the device's transaction rules.
module tb_adxl345_seq;

  localparam int unsigned SDIV = 100;
  localparam int unsigned RW   = 30;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        cmd_valid, cmd_nack, sample_valid, init_done, busy, error;
  logic        cmd_ready = 1'b0;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid = 1'b0;
  logic [7:0]  rsp_data = 8'h00;
  logic        rsp_nack = 1'b0;
  logic [15:0] accel_x, accel_y, accel_z;

  adxl345_seq #(.DEV_ADDR(7'h53), .SAMPLE_DIV(SDIV), .RETRY_WAIT(RW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_nack(cmd_nack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .sample_valid(sample_valid), .init_done(init_done), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  op;
    logic [7:0]  data;
    logic        nack;
  } cmd_t;

  cmd_t        cmd_log[$];
  logic [7:0]  rd_fixed[$];
  logic [7:0]  rd_hist[$];
  logic [47:0] sv_q[$];
  logic [10:0] stall_q[$];
  logic [15:0] init_tab [8] = '{16'h310B, 16'h2C0B, 16'h2404, 16'h2502,
                                16'h2602, 16'h27FF, 16'h2D00, 16'h2D08};

  int checks = 0, failures = 0;
  int cyc = 0, latency = 1, cnt = 0, nack_cd = -1, stall_cnt = 0, overlap_err = 0;
  bit rdy_always = 1'b0, stall_next = 1'b0, outstanding = 1'b0, bfm_nack = 1'b0;
  logic [7:0] bfm_data = 8'h00;

  // I2C master BFM: everything is sampled and driven on the falling edge.
  always @(negedge clk) begin
    cmd_t e;
    cyc++;
    if (sample_valid) sv_q.push_back({accel_z, accel_y, accel_x});
    if (!reset_n) begin
      outstanding = 1'b0; rsp_valid = 1'b0; cmd_ready = 1'b0; stall_cnt = 0;
    end else begin
      rsp_valid = 1'b0;
      if (outstanding) begin
        if (cmd_valid) overlap_err++;
        cmd_ready = 1'b0;
        if (cnt == 0) begin
          rsp_valid = 1'b1; rsp_data = bfm_data; rsp_nack = bfm_nack; outstanding = 1'b0;
        end else cnt--;
      end else if (cmd_valid) begin
        if (stall_next || stall_cnt > 0) begin
          if (stall_next) begin stall_next = 1'b0; stall_cnt = 7; end
          stall_q.push_back({cmd_valid, cmd_op, cmd_data});
          stall_cnt--;
          cmd_ready = 1'b0;
        end else begin
          cmd_ready = rdy_always || ($urandom_range(0, 3) != 0);
          if (cmd_ready) begin
            e.cyc = cyc; e.op = cmd_op; e.data = cmd_data; e.nack = cmd_nack;
            cmd_log.push_back(e);
            bfm_nack = 1'b0;
            bfm_data = 8'($urandom);
            if (cmd_op == 2'd3) begin
              if (rd_fixed.size() > 0) bfm_data = rd_fixed.pop_front();
              rd_hist.push_back(bfm_data);
            end
            if (nack_cd == 0 && cmd_op == 2'd2) bfm_nack = 1'b1;
            if (nack_cd >= 0) nack_cd--;
            outstanding = 1'b1;
            cnt = latency - 1;
          end
        end
      end else cmd_ready = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Data only matters for WRITE, the nack flag only for READ.
  task automatic expect_cmd(input string tag, input logic [1:0] op, input logic [7:0] data,
                            input logic nack, output cmd_t got);
    int n = 0;
    got = '0;
    while (cmd_log.size() == 0 && n < 600) begin @(negedge clk); n++; end
    if (cmd_log.size() == 0) begin check({tag, "_timeout"}, 48'd0, 48'd1); return; end
    got = cmd_log.pop_front();
    check(tag, {got.op, (op == 2'd2) ? got.data : 8'h00, (op == 2'd3) ? got.nack : 1'b0},
               {op, (op == 2'd2) ? data : 8'h00, (op == 2'd3) ? nack : 1'b0});
  endtask

  task automatic expect_init_entry(input int i, input bit skip_start);
    cmd_t g;
    string t = $sformatf("init%0d", i);
    if (!skip_start) expect_cmd({t, "_start"}, 2'd0, 8'h00, 1'b0, g);
    expect_cmd({t, "_addr"}, 2'd2, 8'hA6, 1'b0, g);
    expect_cmd({t, "_reg"},  2'd2, init_tab[i][15:8], 1'b0, g);
    expect_cmd({t, "_data"}, 2'd2, init_tab[i][7:0], 1'b0, g);
    expect_cmd({t, "_stop"}, 2'd1, 8'h00, 1'b0, g);
  endtask

  task automatic burst_head(input string t, output logic [31:0] first);
    cmd_t g;
    expect_cmd({t, "_start"},   2'd0, 8'h00, 1'b0, g);
    first = g.cyc;
    expect_cmd({t, "_addrw"},   2'd2, 8'hA6, 1'b0, g);
    expect_cmd({t, "_reg"},     2'd2, 8'h32, 1'b0, g);
    expect_cmd({t, "_restart"}, 2'd0, 8'h00, 1'b0, g);
    expect_cmd({t, "_addrr"},   2'd2, 8'hA7, 1'b0, g);
    expect_cmd({t, "_rd0"},     2'd3, 8'h00, 1'b0, g);
  endtask

  task automatic burst_tail(input string t, output logic [31:0] last);
    cmd_t g;
    for (int k = 1; k < 6; k++)
      expect_cmd($sformatf("%s_rd%0d", t, k), 2'd3, 8'h00, (k == 5), g);
    expect_cmd({t, "_stop"}, 2'd1, 8'h00, 1'b0, g);
    last = g.cyc;
  endtask

  task automatic expect_burst(input string t, output logic [31:0] first, output logic [31:0] last);
    burst_head(t, first);
    burst_tail(t, last);
  endtask

  // Next published sample must equal the six bytes the BFM handed out, little-endian pairs.
  task automatic check_sample(input string t, output logic [47:0] s);
    int n = 0;
    logic [7:0] b [6];
    s = '0;
    while (sv_q.size() == 0 && n < 2000) begin @(negedge clk); n++; end
    if (sv_q.size() == 0 || rd_hist.size() < 6) begin
      check({t, "_sample_timeout"}, 48'd0, 48'd1);
      return;
    end
    s = sv_q.pop_front();
    for (int i = 0; i < 6; i++) b[i] = rd_hist.pop_front();
    check({t, "_x"}, s[15:0],  {b[1], b[0]});
    check({t, "_y"}, s[31:16], {b[3], b[2]});
    check({t, "_z"}, s[47:32], {b[5], b[4]});
  endtask

  task automatic wait_init_done(input string t);
    int n = 0;
    while (!init_done && n < 50) begin @(negedge clk); n++; end
    check({t, "_init_done"}, init_done, 1'b1);
  endtask

  initial begin
    cmd_t g, gs;
    logic [47:0] s;
    logic [31:0] f0, l0, f1, l1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_flags", {init_done, error, sample_valid}, 3'b000);
    check("rst_accel", {accel_x, accel_y, accel_z}, 48'd0);

    // Init table then a directed burst
    rd_fixed = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00};
    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) expect_init_entry(i, 1'b0);
    check("init_done_before_last_rsp", init_done, 1'b0);
    wait_init_done("init");
    check("init_error", error, 1'b0);
    expect_burst("b0", f0, l0);
    check_sample("b0", s);
    check("b0_xyz_const", s, {16'h0001, 16'hABCD, 16'h1234});
    repeat (2) @(negedge clk);
    check("b0_one_pulse", sv_q.size(), 0);

    // Randomized latency and ready
    for (int k = 0; k < 3; k++) begin
      latency = $urandom_range(1, 3);
      expect_burst($sformatf("rb%0d", k), f0, l0);
      check_sample($sformatf("rb%0d", k), s);
    end

    // Stall the next START for 7 cycles
    latency = 1;
    stall_next = 1'b1;
    expect_burst("stall", f0, l0);
    check("stall_len", stall_q.size(), 7);
    for (int i = 0; i < stall_q.size(); i++) begin
      check($sformatf("stall%0d_valid_op", i), stall_q[i][10:8], 3'b100);
      check($sformatf("stall%0d_data", i), stall_q[i][7:0], stall_q[0][7:0]);
    end
    check_sample("stall", s);

    // Disable during RD_BYTE
    burst_head("dis", f0);
    enable = 1'b0;
    burst_tail("dis", l0);
    check_sample("dis", s);
    repeat (5) @(negedge clk);
    check("dis_busy", busy, 1'b0);
    check("dis_no_cmds", cmd_log.size(), 0);
    check("dis_init_kept", init_done, 1'b1);

    // NACK on entry 3 address byte, retry from the top of the table
    rdy_always = 1'b1;
    nack_cd = 16;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) expect_init_entry(i, 1'b0);
    expect_cmd("init3_start", 2'd0, 8'h00, 1'b0, g);
    expect_cmd("init3_addr_nacked", 2'd2, 8'hA6, 1'b0, g);
    expect_cmd("err_stop", 2'd1, 8'h00, 1'b0, gs);
    check("err_flag", error, 1'b1);
    check("err_init_done_clr", init_done, 1'b0);
    expect_cmd("retry_start", 2'd0, 8'h00, 1'b0, g);
    check("retry_gap", (g.cyc - gs.cyc >= RW) && (g.cyc - gs.cyc <= RW + 6), 1'b1);
    expect_init_entry(0, 1'b1);
    for (int i = 1; i < 8; i++) expect_init_entry(i, 1'b0);
    wait_init_done("retry");
    check("retry_error_sticky", error, 1'b1);

    // Slow master: bursts exceed SAMPLE_DIV and must run back to back
    latency = 20;
    expect_burst("slow0", f0, l0);
    check_sample("slow0", s);
    expect_burst("slow1", f1, l1);
    check("b2b_gap", (f1 > l0) && (f1 - l0 <= 30), 1'b1);
    check_sample("slow1", s);
    check("no_overlap", overlap_err, 0);

    // Reset mid-burst
    expect_cmd("slow2_start", 2'd0, 8'h00, 1'b0, g);
    expect_cmd("slow2_addrw", 2'd2, 8'hA6, 1'b0, g);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mrst_valid", cmd_valid, 1'b0);
    check("mrst_cmd", {cmd_op, cmd_data, cmd_nack}, 11'd0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_flags", {init_done, error, sample_valid}, 3'b000);
    check("mrst_accel", {accel_x, accel_y, accel_z}, 48'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
